cordic_angle_reducer: RTL and testbench

//   Upstream stage of the CORDIC rotator: accepts an angle in radians on a valid/ready handshake.

---
 rtl/cordic_pkg.sv | 17 +
 rtl/cordic_quad_vector.sv | 29 ++
 rtl/cordic_angle_reducer.sv | 173 +++++++++++++++++
 tb/tb_cordic_angle_reducer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC angle reducer.
// Angles are Q3.29 radians; coordinates are Q2.14.
package cordic_pkg;

  localparam logic [31:0] HALF_PI_Q329     = 32'h3243F6A9;
  localparam logic [31:0] INV_HALF_PI_Q032 = 32'hA2F9836E;
  localparam logic [15:0] GAIN_Q214        = 16'h26DD;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_MULT   = 3'd1;
  localparam state_t S_REDUCE = 3'd2;
  localparam state_t S_ISSUE  = 3'd3;
  localparam state_t S_WAIT   = 3'd4;

endpackage

// File: rtl/cordic_quad_vector.sv
// Maps quadrant q mod 4 to the rotator start vector,
// i.e. (GAIN, 0) rotated by q*pi/2.
module cordic_quad_vector
  import cordic_pkg::*;
#(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] GAIN = GAIN_Q214
) (
  input  logic [1:0]       q,
  output logic [WIDTH-1:0] x_start,
  output logic [WIDTH-1:0] y_start
);

  logic [WIDTH-1:0] neg_gain;

  assign neg_gain = '0 - GAIN;

  always_comb begin
    x_start = '0;
    y_start = '0;
    unique case (1'b1)
      (q == 2'd0): x_start = GAIN;
      (q == 2'd1): y_start = GAIN;
      (q == 2'd2): x_start = neg_gain;
      default:     y_start = neg_gain;
    endcase
  end

endmodule

// File: rtl/cordic_angle_reducer.sv
// Quadrant reduction ahead of the CORDIC rotator.
// Optional WAIT watchdog: define CORDIC_REDUCER_TIMEOUT_EN.
module cordic_angle_reducer
  import cordic_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter int               ANGLE_WIDTH    = 32,
  parameter logic [WIDTH-1:0] GAIN           = GAIN_Q214,
  parameter int               TIMEOUT_CYCLES = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ANGLE_WIDTH-1:0] angle_in,
  output logic                   cordic_start,
  output logic [WIDTH-1:0]       cordic_x_start,
  output logic [WIDTH-1:0]       cordic_y_start,
  output logic [ANGLE_WIDTH-1:0] cordic_angle,
  input  logic                   cordic_done,
  output logic [1:0]             quadrant,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int AW = ANGLE_WIDTH;
  localparam int PW = 2 * AW;
  localparam int RW = AW + 3;
  localparam logic [PW-1:0] HALF_Q = PW'(1) << (PW - 4);

  state_t           state_q, state_d;
  logic [AW-1:0]    angle_q, angle_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [AW-1:0]    res_q, res_d;
  logic [1:0]       quad_q, quad_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             done_d_q;

  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    k_ext;
  logic [2:0]       q_full;
  logic [RW-1:0]    a35;
  logic [RW-1:0]    q35;
  logic [RW-1:0]    hp35;
  logic [AW-1:0]    res_new;
  logic [WIDTH-1:0] qv_x;
  logic [WIDTH-1:0] qv_y;
  logic             done_rise;
  logic             tmo_hit;

  // signed angle times unsigned 2/pi; the true product fits in PW bits
  assign a_ext = {{AW{angle_q[AW-1]}}, angle_q};
  assign k_ext = {AW'(0), AW'(INV_HALF_PI_Q032)};

  // round half up: top 3 bits of (prod + 0.5 quadrant) are q in -3..+3
  assign q_full  = 3'((prod_q + HALF_Q) >> (PW - 3));
  assign a35     = {{3{angle_q[AW-1]}}, angle_q};
  assign q35     = {{AW{q_full[2]}}, q_full};
  assign hp35    = {3'b000, AW'(HALF_PI_Q329)};
  assign res_new = AW'(a35 - q35 * hp35);

  assign done_rise = cordic_done & ~done_d_q;

  cordic_quad_vector #(
    .WIDTH (WIDTH),
    .GAIN  (GAIN)
  ) u_quad_vector (
    .q       (q_full[1:0]),
    .x_start (qv_x),
    .y_start (qv_y)
  );

`ifdef CORDIC_REDUCER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign tmo_hit = (state_q == S_WAIT) && !done_rise
                && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_timeout = tmo_hit;
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    prod_d  = prod_q;
    res_d   = res_q;
    quad_d  = quad_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (in_valid) begin
          angle_d = angle_in;
          state_d = S_MULT;
        end
      end
      (state_q == S_MULT): begin
        prod_d  = a_ext * k_ext;
        state_d = S_REDUCE;
      end
      (state_q == S_REDUCE): begin
        res_d   = res_new;
        quad_d  = q_full[1:0];
        x_d     = qv_x;
        y_d     = qv_y;
        state_d = S_ISSUE;
      end
      (state_q == S_ISSUE): begin
        state_d = S_WAIT;
      end
      (state_q == S_WAIT): begin
        if (done_rise || tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // done_d tracks the done level, so a level held over from the
  // previous operation never looks like a fresh rising edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      angle_q  <= '0;
      prod_q   <= '0;
      res_q    <= '0;
      quad_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      done_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      angle_q  <= angle_d;
      prod_q   <= prod_d;
      res_q    <= res_d;
      quad_q   <= quad_d;
      x_q      <= x_d;
      y_q      <= y_d;
      done_d_q <= cordic_done;
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign cordic_start   = (state_q == S_ISSUE);
  assign cordic_x_start = x_q;
  assign cordic_y_start = y_q;
  assign cordic_angle   = res_q;
  assign quadrant       = quad_q;

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// Directed testbench for cordic_angle_reducer.
// Watchdog checks run when CORDIC_REDUCER_TIMEOUT_EN is defined.
module tb_cordic_angle_reducer;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] angle_in;
  logic        cordic_start;
  logic [15:0] cordic_x_start;
  logic [15:0] cordic_y_start;
  logic [31:0] cordic_angle;
  logic        cordic_done;
  logic [1:0]  quadrant;
  logic        busy;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int starts   = 0;
  int errs     = 0;

  cordic_angle_reducer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .angle_in       (angle_in),
    .cordic_start   (cordic_start),
    .cordic_x_start (cordic_x_start),
    .cordic_y_start (cordic_y_start),
    .cordic_angle   (cordic_angle),
    .cordic_done    (cordic_done),
    .quadrant       (quadrant),
    .busy           (busy),
    .err_timeout    (err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (cordic_start) starts++;
    if (err_timeout) errs++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a);
    int ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk("ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    angle_in = a;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = 99;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (cordic_start) begin
        lat = i + 1;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] a,
                        input logic [1:0]  eq,
                        input logic [15:0] ex,
                        input logic [15:0] ey,
                        input logic [31:0] er);
    int lat;
    int s0;
    s0 = starts;
    send(a);
    wait_start(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd3);
    chk({tag, "_q"}, 64'(quadrant), 64'(eq));
    chk({tag, "_x"}, 64'(cordic_x_start), 64'(ex));
    chk({tag, "_y"}, 64'(cordic_y_start), 64'(ey));
    chk({tag, "_r"}, 64'(cordic_angle), 64'(er));
    @(negedge clock);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    cordic_done = 1'b1;
    @(negedge clock);
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    chk({tag, "_nstart"}, 64'(starts - s0), 64'd1);
    cordic_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int s0;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    angle_in    = '0;
    cordic_done = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(cordic_start), 64'd0);
    chk("rst_q", 64'(quadrant), 64'd0);
    chk("rst_x", 64'(cordic_x_start), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("zero",  32'h00000000, 2'd0, 16'h26DD, 16'h0000, 32'h00000000);
    run_op("hpi",   32'h3243F6A9, 2'd1, 16'h0000, 16'h26DD, 32'h00000000);
    run_op("mpi",   32'h9B7812AF, 2'd2, 16'hD923, 16'h0000, 32'h00000001);
    run_op("one",   32'h20000000, 2'd1, 16'h0000, 16'h26DD, 32'hEDBC0957);
    run_op("mone",  32'hE0000000, 2'd3, 16'h0000, 16'hD923, 32'h1243F6A9);
    run_op("qlo",   32'h1921FB00, 2'd0, 16'h26DD, 16'h0000, 32'h1921FB00);
    run_op("qhi",   32'h1921FC00, 2'd1, 16'h0000, 16'h26DD, 32'hE6DE0557);
    run_op("m4",    32'h80000000, 2'd1, 16'h0000, 16'h26DD, 32'h16CBE3FB);

    // done held high across back-to-back requests
    send(32'h20000000);
    wait_start(lat);
    @(negedge clock);
    cordic_done = 1'b1;
    @(negedge clock);
    chk("b2b_rdy1", 64'(in_ready), 64'd1);
    s0 = starts;
    in_valid = 1'b1;
    angle_in = 32'hE0000000;
    @(posedge clock);
    wait_start(lat);
    chk("b2b_lat", 64'(lat), 64'd3);
    chk("b2b_q", 64'(quadrant), 64'd3);
    repeat (5) @(negedge clock);
    chk("b2b_held", 64'(in_ready), 64'd0);
    chk("b2b_nstart", 64'(starts - s0), 64'd1);
    in_valid = 1'b0;
    cordic_done = 1'b0;
    @(negedge clock);
    cordic_done = 1'b1;
    chk("b2b_pre", 64'(in_ready), 64'd0);
    @(negedge clock);
    chk("b2b_rdy2", 64'(in_ready), 64'd1);
    cordic_done = 1'b0;

    // done edge while idle is ignored
    @(negedge clock);
    cordic_done = 1'b1;
    @(negedge clock);
    cordic_done = 1'b0;
    @(negedge clock);
    chk("idle_done", 64'(busy), 64'd0);

    // reset in WAIT
    send(32'hE0000000);
    wait_start(lat);
    @(negedge clock);
    chk("rw_busy", 64'(busy), 64'd1);
    s0 = starts;
    reset_n = 1'b0;
    #1;
    chk("rw_ready", 64'(in_ready), 64'd1);
    chk("rw_nbusy", 64'(busy), 64'd0);
    chk("rw_start", 64'(cordic_start), 64'd0);
    chk("rw_y", 64'(cordic_y_start), 64'd0);
    chk("rw_r", 64'(cordic_angle), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("rw_nostart", 64'(starts - s0), 64'd0);
    chk("rw_idle", 64'(in_ready), 64'd1);

    // no done at all
    send(32'h00000000);
    wait_start(lat);
`ifdef CORDIC_REDUCER_TIMEOUT_EN
    lat = 999;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (err_timeout) begin
        lat = i + 1;
        break;
      end
    end
    chk("tmo_cycle", 64'(lat), 64'd64);
    @(negedge clock);
    chk("tmo_idle", 64'(in_ready), 64'd1);
    chk("tmo_errs", 64'(errs), 64'd1);
`else
    repeat (100) @(negedge clock);
    chk("notmo_busy", 64'(busy), 64'd1);
    chk("notmo_errs", 64'(errs), 64'd0);
    cordic_done = 1'b1;
    @(negedge clock);
    chk("notmo_idle", 64'(in_ready), 64'd1);
    cordic_done = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
